spi_ram_arbiter: RTL and testbench

//  Shares the single-port RAM between the SPI slave command path and a local host port.
//  - SPI side: decodes the 10-bit SPI words (cmd in [9:8], payload in [7:0]) and latches read/write addresses.
//  - Host side: accepts direct valid/ready accesses.
//  - Round-robin arbitration between the two; at most one RAM access issued per cycle.
//  - Read data is routed back to the owner: tx_data/tx_valid for SPI, host_rdata/host_rvalid for host.

---
 rtl/spi_ram_pkg.sv | 25 ++
 rtl/rr_arb2.sv | 36 +++
 rtl/spi_ram_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_spi_ram_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI/host RAM arbiter: SPI command encoding and
// read-owner tags used by the return pipeline.
package spi_ram_pkg;

  localparam int CMD_W = 2;

  typedef enum logic [CMD_W-1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

  // Encoding doubles as the requester index in the arbiter's req/gnt vectors.
  typedef enum logic {
    OWN_SPI  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  // Data commands are the ones that turn into a RAM access.
  function automatic logic is_data_cmd(input cmd_e c);
    return (c == WR_DATA) || (c == RD_DATA);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. Requester 0 is SPI, requester 1 is host.
// The pointer names the requester that wins the next tie; it moves to the
// other requester whenever a grant is taken.
module rr_arb2
  import spi_ram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  owner_e ptr_q;

  // One-hot grant: a lone requester always wins, a tie goes to the pointer.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (ptr_q == OWN_SPI) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Pointer register: after a grant, favour the requester that did not win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= OWN_SPI;
    end else if (advance && (gnt != 2'b00)) begin
      ptr_q <= gnt[0] ? OWN_HOST : OWN_SPI;
    end
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares one single-port RAM between the SPI slave command path and a local
// host port. SPI words are decoded into address latches and a single pending
// access; host accesses arrive as valid/ready. A round-robin arbiter issues at
// most one RAM access per cycle and read data is routed back to its owner.
module spi_ram_arbiter
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int DATA_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CMD_W+ADDR_SIZE-1:0] rx_data,
  input  logic                       rx_valid,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_valid,
  input  logic                       host_req,
  input  logic                       host_we,
  input  logic [ADDR_SIZE-1:0]       host_addr,
  input  logic [DATA_W-1:0]          host_wdata,
  output logic                       host_gnt,
  output logic                       host_rvalid,
  output logic [DATA_W-1:0]          host_rdata,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [ADDR_SIZE-1:0]       mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       spi_overrun
);

  if (MEM_DEPTH > (1 << ADDR_SIZE)) begin : g_depth_chk
    $error("MEM_DEPTH does not fit in ADDR_SIZE address bits");
  end

  // SPI word decode
  logic                 rx_valid_q;
  logic                 rx_edge;
  cmd_e                 rx_cmd;
  logic [ADDR_SIZE-1:0] rx_payload;
  logic                 data_cmd;

  // SPI address latches and the single pending SPI access
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic                 spi_pend;
  logic                 pend_we;
  logic [ADDR_SIZE-1:0] pend_addr;
  logic [DATA_W-1:0]    pend_wdata;

  // Arbitration
  logic [1:0] arb_req;
  logic [1:0] arb_gnt;
  logic       spi_win;
  logic       host_win;
  logic       read_win;

  // Read-owner tag pipeline and SPI read-data hold
  logic              vld_p0;
  logic              vld_p1;
  owner_e            own_p0;
  owner_e            own_p1;
  logic              spi_ret;
  logic              tx_valid_q;
  logic [DATA_W-1:0] tx_data_q;

  assign rx_cmd     = cmd_e'(rx_data[CMD_W+ADDR_SIZE-1 -: CMD_W]);
  assign rx_payload = rx_data[ADDR_SIZE-1:0];
  assign rx_edge    = rx_valid && !rx_valid_q;
  assign data_cmd   = rx_edge && is_data_cmd(rx_cmd);

  // A command captured this cycle only becomes a candidate next cycle, so a
  // simultaneous host request wins the cycle of the SPI edge.
  assign arb_req  = {host_req, spi_pend};
  assign spi_win  = arb_gnt[OWN_SPI];
  assign host_win = arb_gnt[OWN_HOST];
  assign host_gnt = host_win;
  assign read_win = (spi_win && !pend_we) || (host_win && !host_we);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .advance (|arb_req),
    .gnt     (arb_gnt)
  );

  // Registered copy of rx_valid; rx_valid is a level held for several cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
    end
  end

  // Address-setting commands only update the latches; no RAM access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr <= '0;
      rd_addr <= '0;
    end else if (rx_edge) begin
      if (rx_cmd == WR_ADDR) wr_addr <= rx_payload;
      if (rx_cmd == RD_ADDR) rd_addr <= rx_payload;
    end
  end

  // Pending SPI access: a data command arriving while one is still pending is
  // dropped (the older one is kept) and the sticky overrun flag is raised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_pend    <= 1'b0;
      pend_we     <= 1'b0;
      pend_addr   <= '0;
      pend_wdata  <= '0;
      spi_overrun <= 1'b0;
    end else begin
      if (spi_win) spi_pend <= 1'b0;
      if (data_cmd) begin
        if (spi_pend) begin
          spi_overrun <= 1'b1;
        end else begin
          spi_pend   <= 1'b1;
          pend_we    <= (rx_cmd == WR_DATA);
          pend_addr  <= (rx_cmd == WR_DATA) ? wr_addr : rd_addr;
          pend_wdata <= DATA_W'(rx_payload);
        end
      end
    end
  end

  // ---- stage p0: winner registered onto the RAM bus, read tag launched ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      vld_p0    <= 1'b0;
      own_p0    <= OWN_SPI;
    end else begin
      mem_en <= spi_win || host_win;
      vld_p0 <= read_win;
      own_p0 <= spi_win ? OWN_SPI : OWN_HOST;
      if (spi_win) begin
        mem_we    <= pend_we;
        mem_addr  <= pend_addr;
        mem_wdata <= pend_wdata;
      end else if (host_win) begin
        mem_we    <= host_we;
        mem_addr  <= host_addr;
        mem_wdata <= host_wdata;
      end else begin
        mem_we    <= 1'b0;
      end
    end
  end

  // ---- stage p1: tag aligned with mem_rdata from the RAM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      own_p1 <= OWN_SPI;
    end else begin
      vld_p1 <= vld_p0;
      own_p1 <= own_p0;
    end
  end

  assign spi_ret     = vld_p1 && (own_p1 == OWN_SPI);
  assign host_rvalid = vld_p1 && (own_p1 == OWN_HOST);
  assign host_rdata  = host_rvalid ? mem_rdata : '0;
  assign tx_valid    = tx_valid_q || spi_ret;
  assign tx_data     = spi_ret ? mem_rdata : tx_data_q;

  // SPI read result is held until the next accepted SPI command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else if (spi_ret) begin
      tx_valid_q <= 1'b1;
      tx_data_q  <= mem_rdata;
    end else if (rx_edge) begin
      tx_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Bench for spi_ram_arbiter: RAM stub, transaction-level reference model,
// per-cycle output comparison and directed scenarios with literal checks.
module tb_spi_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       host_req = 1'b0;
  logic       host_we = 1'b0;
  logic [7:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       host_gnt;
  logic       host_rvalid;
  logic [7:0] host_rdata;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic       spi_overrun;

  int tests = 0;
  int fails = 0;

  spi_ram_arbiter #(.MEM_DEPTH(256), .ADDR_SIZE(8), .DATA_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .spi_overrun (spi_overrun)
  );

  always #5 clk = ~clk;

  // RAM stub: preloaded with addr ^ 0x5A, one-cycle read latency.
  logic [7:0] ram [256];
  logic       ram_ready = 1'b0;
  int         wr_count = 0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h5A;
      ram_ready <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        wr_count      <= wr_count + 1;
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         due;
    bit         spi;
    logic [7:0] data;
  } ret_t;

  ret_t       retq[$];
  bit         m_rxq, m_pend, m_pend_we, m_ovr, m_last_host, m_en, m_we, m_own_spi, m_txv;
  logic [7:0] m_wr_addr, m_rd_addr, m_pend_addr, m_pend_data, m_addr, m_wd, m_txd;
  logic [7:0] m_mem [256];
  int         cyc = 0;

  // bit 0: SPI wins this cycle, bit 1: host wins this cycle
  function automatic logic [1:0] win_now();
    if (m_pend && host_req) return m_last_host ? 2'b01 : 2'b10;
    return {host_req, m_pend};
  endfunction

  task automatic model_reset();
    m_rxq = 0; m_pend = 0; m_pend_we = 0; m_ovr = 0; m_last_host = 1;
    m_en = 0; m_we = 0; m_own_spi = 0; m_txv = 0;
    m_wr_addr = 0; m_rd_addr = 0; m_pend_addr = 0; m_pend_data = 0;
    m_addr = 0; m_wd = 0; m_txd = 0;
    retq.delete();
  endtask

  task automatic model_step();
    logic [1:0] w;
    logic [1:0] cmd;
    logic [7:0] pay;
    bit         edge_s, old_pend, ret_spi;
    w      = win_now();
    edge_s = rx_valid && !m_rxq;
    cmd    = rx_data[9:8];
    pay    = rx_data[7:0];
    ret_spi = 0;
    if (retq.size() > 0 && retq[0].due == cyc) begin
      if (retq[0].spi) begin
        m_txv = 1; m_txd = retq[0].data; ret_spi = 1;
      end
      void'(retq.pop_front());
    end
    if (!ret_spi && edge_s) m_txv = 0;
    if (m_en) begin
      if (m_we) m_mem[m_addr] = m_wd;
      else retq.push_back('{cyc + 1, m_own_spi, m_mem[m_addr]});
    end
    if (w[0]) begin
      m_en = 1; m_we = m_pend_we; m_addr = m_pend_addr; m_wd = m_pend_data;
      m_own_spi = 1; m_last_host = 0;
    end else if (w[1]) begin
      m_en = 1; m_we = host_we; m_addr = host_addr; m_wd = host_wdata;
      m_own_spi = 0; m_last_host = 1;
    end else begin
      m_en = 0; m_we = 0;
    end
    old_pend = m_pend;
    if (w[0]) m_pend = 0;
    if (edge_s && cmd[0]) begin
      if (old_pend) m_ovr = 1;
      else begin
        m_pend = 1;
        m_pend_we = (cmd == 2'b01);
        m_pend_addr = (cmd == 2'b01) ? m_wr_addr : m_rd_addr;
        m_pend_data = pay;
      end
    end
    if (edge_s && cmd == 2'b00) m_wr_addr = pay;
    if (edge_s && cmd == 2'b10) m_rd_addr = pay;
    m_rxq = rx_valid;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = 8'(i) ^ 8'h5A;
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
      cyc++;
    end
  end

  // ---------------- per-cycle comparison ----------------
  logic [7:0] rd_q[$];
  int         rv_cnt = 0;

  initial begin
    logic [1:0] w;
    bit         ret, rs, rh;
    logic [7:0] rd;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_host_rvalid", 32'(host_rvalid), 0);
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_spi_overrun", 32'(spi_overrun), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
      end else begin
        w   = win_now();
        ret = (retq.size() > 0) && (retq[0].due == cyc);
        rs  = ret && retq[0].spi;
        rh  = ret && !retq[0].spi;
        rd  = ret ? retq[0].data : 8'h00;
        check("host_gnt", 32'(host_gnt), 32'(w[1]));
        check("mem_en", 32'(mem_en), 32'(m_en));
        check("mem_we", 32'(mem_we), 32'(m_we));
        check("mem_addr", 32'(mem_addr), 32'(m_addr));
        check("mem_wdata", 32'(mem_wdata), 32'(m_wd));
        check("host_rvalid", 32'(host_rvalid), 32'(rh));
        check("host_rdata", 32'(host_rdata), 32'(rh ? rd : 8'h00));
        check("tx_valid", 32'(tx_valid), 32'(m_txv | rs));
        check("tx_data", 32'(tx_data), 32'(rs ? rd : m_txd));
        check("spi_overrun", 32'(spi_overrun), 32'(m_ovr));
        if (host_rvalid) begin
          rd_q.push_back(host_rdata);
          rv_cnt++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic spi_word(input logic [9:0] w, input int hold);
    rx_data  = w;
    rx_valid = 1'b1;
    repeat (hold) step();
    rx_valid = 1'b0;
    step();
  endtask

  initial begin
    int         n0, base, iters, budget;
    logic [4:0] pat;
    logic       g;

    repeat (3) step();
    rst_n = 1'b1;
    step();

    // 1: SPI write then read back through the SPI path
    spi_word(10'h0A5, 1);
    spi_word(10'h13C, 1);
    spi_word(10'h2A5, 1);
    spi_word(10'h300, 1);
    repeat (5) step();
    check("t1_ram_a5", 32'(ram[8'hA5]), 32'h3C);
    check("t1_tx_valid", 32'(tx_valid), 1);
    check("t1_tx_data", 32'(tx_data), 32'h3C);
    spi_word(10'h000, 1);
    check("t1_tx_valid_cleared", 32'(tx_valid), 0);

    // 2: long rx_valid level produces one write only
    spi_word(10'h010, 1);
    n0 = wr_count;
    spi_word(10'h177, 5);
    repeat (4) step();
    check("t2_write_count", 32'(wr_count - n0), 1);
    check("t2_ram_10", 32'(ram[8'h10]), 32'h77);

    // 3: host reads 0..3 competing with a pending SPI write
    spi_word(10'h020, 1);
    base     = rd_q.size();
    rx_data  = 10'h199;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    iters = 0; budget = 20; pat = '0;
    while (iters < 4 && budget > 0) begin
      host_req  = 1'b1;
      host_we   = 1'b0;
      host_addr = 8'(iters);
      @(negedge clk);
      g   = host_gnt;
      pat = {pat[3:0], g};
      step();
      if (g) iters++;
      budget--;
    end
    host_req = 1'b0;
    check("t3_all_granted", 32'(iters), 4);
    check("t3_gnt_pattern", 32'(pat), 32'b10111);
    repeat (4) step();
    check("t3_rd_count", 32'(rd_q.size() - base), 4);
    if (rd_q.size() - base == 4) begin
      check("t3_rd0", 32'(rd_q[base]), 32'h5A);
      check("t3_rd1", 32'(rd_q[base + 1]), 32'h5B);
      check("t3_rd2", 32'(rd_q[base + 2]), 32'h58);
      check("t3_rd3", 32'(rd_q[base + 3]), 32'h59);
    end
    check("t3_ram_20", 32'(ram[8'h20]), 32'h99);

    // 4: SPI edge and host request in the same cycle
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h30; host_wdata = 8'h55;
    rx_data = 10'h144; rx_valid = 1'b1;
    @(negedge clk);
    check("t4_host_gnt", 32'(host_gnt), 1);
    step();
    host_req = 1'b0; host_we = 1'b0; rx_valid = 1'b0;
    @(negedge clk);
    check("t4_host_wr_addr", 32'(mem_addr), 32'h30);
    check("t4_host_wr_data", 32'(mem_wdata), 32'h55);
    step();
    @(negedge clk);
    check("t4_spi_wr_en", 32'(mem_en & mem_we), 1);
    check("t4_spi_wr_addr", 32'(mem_addr), 32'h20);
    check("t4_spi_wr_data", 32'(mem_wdata), 32'h44);
    step();

    // 5: second WR_DATA while the first is still pending
    spi_word(10'h040, 1);
    n0 = wr_count;
    rx_data = 10'h111; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 8'h05;
    step();
    rx_data = 10'h122; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    step();
    step();
    host_req = 1'b0;
    repeat (4) step();
    check("t5_overrun", 32'(spi_overrun), 1);
    check("t5_write_count", 32'(wr_count - n0), 1);
    check("t5_ram_40", 32'(ram[8'h40]), 32'h11);

    // 6: reset right after a host read grant
    spi_word(10'h240, 1);
    spi_word(10'h300, 1);
    repeat (4) step();
    check("t6_tx_before", 32'(tx_valid), 1);
    check("t6_tx_data_before", 32'(tx_data), 32'h11);
    base = rv_cnt;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h03;
    step();
    host_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_async_mem_en", 32'(mem_en), 0);
    check("t6_async_tx_valid", 32'(tx_valid), 0);
    check("t6_async_tx_data", 32'(tx_data), 0);
    check("t6_async_overrun", 32'(spi_overrun), 0);
    check("t6_async_host_gnt", 32'(host_gnt), 0);
    check("t6_async_rvalid", 32'(host_rvalid), 0);
    step();
    rst_n = 1'b1;
    repeat (4) step();
    check("t6_no_late_rvalid", 32'(rv_cnt - base), 0);
    base = rd_q.size();
    host_req = 1'b1; host_addr = 8'h01;
    step();
    host_req = 1'b0;
    repeat (3) step();
    check("t6_post_rd_count", 32'(rd_q.size() - base), 1);
    if (rd_q.size() - base == 1) check("t6_post_rdata", 32'(rd_q[base]), 32'h5B);

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
